join_scheduler: RTL and testbench

JOIN_SCHEDULER -- requirements
Module: join_scheduler

---
 rtl/join_scheduler.sv | 114 +++++++++++
 tb/tb_join_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/join_scheduler.sv
// Fork/join sequencer: launches a masked set of workers, tracks them until
// an ALL/ANY/NONE join condition holds, then reports the completed set and latency.
module join_scheduler #(
  parameter int unsigned N_WORKERS = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [N_WORKERS-1:0] start_mask,
  input  logic [1:0]           join_mode,
  output logic [N_WORKERS-1:0] work_go,
  input  logic [N_WORKERS-1:0] work_done,
  output logic [N_WORKERS-1:0] busy_mask,
  output logic                 done_valid,
  output logic [N_WORKERS-1:0] done_mask,
  output logic [CNT_W-1:0]     join_cycles,
  output logic                 err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_REPORT
  } state_t;

  localparam logic [1:0] MODE_ALL  = 2'b00;
  localparam logic [1:0] MODE_ANY  = 2'b01;
  localparam logic [1:0] MODE_NONE = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  state_t               state;
  logic [1:0]           mode;
  logic [N_WORKERS-1:0] eff_mask;
  logic [N_WORKERS-1:0] acc_mask;

  logic [N_WORKERS-1:0] done_ok;
  logic [N_WORKERS-1:0] done_bad;
  logic [N_WORKERS-1:0] new_mask;
  logic [N_WORKERS-1:0] acc_next;
  logic                 overlap;
  logic                 join_met;

  // A completion only counts for a worker that is actually running.
  assign done_ok  = work_done & busy_mask;
  assign done_bad = work_done & ~busy_mask;
  assign new_mask = start_mask & ~busy_mask;
  assign overlap  = |(start_mask & busy_mask);
  assign acc_next = acc_mask | (done_ok & eff_mask);
  assign join_met = (mode == MODE_ANY) ? |(done_ok & eff_mask) : (acc_next == eff_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mode        <= MODE_ALL;
      eff_mask    <= '0;
      acc_mask    <= '0;
      start_ready <= 1'b1;
      work_go     <= '0;
      busy_mask   <= '0;
      done_valid  <= 1'b0;
      done_mask   <= '0;
      join_cycles <= '0;
      err         <= 1'b0;
    end else begin
      work_go    <= '0;
      done_valid <= 1'b0;
      err        <= |done_bad;
      busy_mask  <= busy_mask & ~work_done;
      case (state)
        S_IDLE: begin
          if (start_valid && start_ready) begin
            state       <= S_LAUNCH;
            start_ready <= 1'b0;
            eff_mask    <= new_mask;
            mode        <= (join_mode == MODE_RSVD) ? MODE_ALL : join_mode;
            acc_mask    <= '0;
            join_cycles <= '0;
            work_go     <= new_mask;
            err         <= (|done_bad) | overlap | (join_mode == MODE_RSVD);
          end
        end
        // Busy bits become visible only after the launch cycle.
        S_LAUNCH: begin
          busy_mask <= (busy_mask & ~work_done) | eff_mask;
          if ((mode == MODE_NONE) || (eff_mask == '0)) begin
            state      <= S_REPORT;
            done_valid <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          acc_mask <= acc_next;
          if (join_cycles != '1) join_cycles <= join_cycles + CNT_W'(1);
          if (join_met) begin
            state      <= S_REPORT;
            done_valid <= 1'b1;
            done_mask  <= acc_next;
          end
        end
        S_REPORT: begin
          state       <= S_IDLE;
          start_ready <= 1'b1;
          done_mask   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_join_scheduler.sv
// Self-checking bench for join_scheduler: table-driven forks with a scoreboard
// of expected join reports, plus hand sequences for error and reset corners.
module tb_join_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [3:0]  start_mask;
  logic [1:0]  join_mode;
  logic [3:0]  work_go;
  logic [3:0]  work_done;
  logic [3:0]  busy_mask;
  logic        done_valid;
  logic [3:0]  done_mask;
  logic [15:0] join_cycles;
  logic        err;

  join_scheduler #(.N_WORKERS(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_mask(start_mask), .join_mode(join_mode),
    .work_go(work_go), .work_done(work_done), .busy_mask(busy_mask),
    .done_valid(done_valid), .done_mask(done_mask),
    .join_cycles(join_cycles), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fork record: inputs, per-worker done time (cycles after launch, 0 = never),
  // and the expected report (latency from launch to done_valid).
  typedef struct {
    logic [3:0]  mask;
    logic [1:0]  mode;
    int          t[4];
    logic [3:0]  exp_dmask;
    logic [15:0] exp_jc;
    logic [3:0]  exp_busy;
    int          exp_lat;
    int          exp_err;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [3:0]  dmask;
    logic [15:0] jc;
    logic [3:0]  busy;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Report monitor: every done_valid must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (rst_n && done_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done_valid", 32'(done_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("done_mask", 32'(done_mask), 32'(e.dmask));
        chk("join_cycles", 32'(join_cycles), 32'(e.jc));
        chk("busy_at_report", 32'(busy_mask), 32'(e.busy));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input int lat, input logic [3:0] dm, input logic [15:0] jc,
                             input logic [3:0] bz);
    exp_t e;
    e.cyc = cyc + 1 + lat;
    e.dmask = dm;
    e.jc = jc;
    e.busy = bz;
    sb.push_back(e);
  endtask

  task automatic sb_drain(input string name);
    chk(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         e0;
    logic [3:0] d;
    e0 = err_cnt;
    chk($sformatf("v%0d_ready", idx), 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    start_mask  = v.mask;
    join_mode   = v.mode;
    expect_push(v.exp_lat, v.exp_dmask, v.exp_jc, v.exp_busy);
    tick();
    chk($sformatf("v%0d_work_go", idx), 32'(work_go), 32'(v.mask));
    chk($sformatf("v%0d_ready_launch", idx), 32'(start_ready), 32'd0);
    start_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      for (int i = 0; i < 4; i++) d[i] = (v.t[i] == c);
      work_done = d;
    end
    tick();
    work_done = '0;
    tick();
    chk($sformatf("v%0d_busy_end", idx), 32'(busy_mask), 32'd0);
    chk($sformatf("v%0d_err_count", idx), 32'(err_cnt - e0), 32'(v.exp_err));
    sb_drain($sformatf("v%0d_report_missing", idx));
  endtask

  vec_t vt[10];
  int   e0;

  initial begin
    // ALL 0101: done[0]@3, done[2]@7
    vt[0] = '{mask:4'b0101, mode:2'b00, t:'{3,0,7,0}, exp_dmask:4'b0101, exp_jc:16'd7, exp_busy:4'b0000, exp_lat:8,  exp_err:0};
    vt[1] = '{mask:4'b0111, mode:2'b01, t:'{5,2,6,0}, exp_dmask:4'b0010, exp_jc:16'd2, exp_busy:4'b0101, exp_lat:3,  exp_err:0};
    vt[2] = '{mask:4'b1111, mode:2'b10, t:'{3,4,5,6}, exp_dmask:4'b0000, exp_jc:16'd0, exp_busy:4'b1111, exp_lat:1,  exp_err:0};
    vt[3] = '{mask:4'b0011, mode:2'b01, t:'{2,2,0,0}, exp_dmask:4'b0011, exp_jc:16'd2, exp_busy:4'b0000, exp_lat:3,  exp_err:0};
    vt[4] = '{mask:4'b0000, mode:2'b00, t:'{0,0,0,0}, exp_dmask:4'b0000, exp_jc:16'd0, exp_busy:4'b0000, exp_lat:1,  exp_err:0};
    vt[5] = '{mask:4'b1111, mode:2'b00, t:'{1,4,2,9}, exp_dmask:4'b1111, exp_jc:16'd9, exp_busy:4'b0000, exp_lat:10, exp_err:0};
    vt[6] = '{mask:4'b1010, mode:2'b01, t:'{0,5,0,8}, exp_dmask:4'b0010, exp_jc:16'd5, exp_busy:4'b1000, exp_lat:6,  exp_err:0};
    vt[7] = '{mask:4'b1000, mode:2'b00, t:'{0,0,0,1}, exp_dmask:4'b1000, exp_jc:16'd1, exp_busy:4'b0000, exp_lat:2,  exp_err:0};
    vt[8] = '{mask:4'b0000, mode:2'b10, t:'{0,0,0,0}, exp_dmask:4'b0000, exp_jc:16'd0, exp_busy:4'b0000, exp_lat:1,  exp_err:0};
    vt[9] = '{mask:4'b0011, mode:2'b11, t:'{2,4,0,0}, exp_dmask:4'b0011, exp_jc:16'd4, exp_busy:4'b0000, exp_lat:5,  exp_err:1};

    rst_n = 1'b0;
    start_valid = 1'b0;
    start_mask = '0;
    join_mode = '0;
    work_done = '0;
    repeat (3) tick();
    chk("rst_ready", 32'(start_ready), 32'd1);
    chk("rst_work_go", 32'(work_go), 32'd0);
    chk("rst_busy", 32'(busy_mask), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_join_cycles", 32'(join_cycles), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 10; k++) run_vec(vt[k], k);

    // Overlap with a worker left running by NONE; start_valid ignored outside IDLE.
    start_valid = 1'b1; start_mask = 4'b0001; join_mode = 2'b10;
    expect_push(1, 4'b0000, 16'd0, 4'b0001);
    tick();
    start_valid = 1'b0;
    tick(); tick();
    chk("ovl_busy_before", 32'(busy_mask), 32'd1);
    e0 = err_cnt;
    start_valid = 1'b1; start_mask = 4'b0011; join_mode = 2'b00;
    expect_push(4, 4'b0010, 16'd3, 4'b0001);
    tick();
    chk("ovl_work_go", 32'(work_go), 32'b0010);
    start_mask = 4'b1100;
    tick();
    chk("busy_start_ignored_1", 32'(work_go), 32'd0);
    tick();
    chk("busy_start_ignored_2", 32'(work_go), 32'd0);
    start_valid = 1'b0;
    tick(); work_done = 4'b0010;
    tick(); work_done = 4'b0000;
    tick(); work_done = 4'b0001;
    tick(); work_done = 4'b0000;
    tick();
    chk("ovl_busy_after", 32'(busy_mask), 32'd0);
    chk("ovl_err_count", 32'(err_cnt - e0), 32'd1);
    sb_drain("ovl_report_missing");

    // Spurious completion on an idle worker.
    e0 = err_cnt;
    work_done = 4'b1000;
    tick(); work_done = '0;
    tick();
    chk("spurious_err", 32'(err_cnt - e0), 32'd1);
    chk("spurious_busy", 32'(busy_mask), 32'd0);

    // Completion during the launch cycle is ignored and flagged.
    e0 = err_cnt;
    start_valid = 1'b1; start_mask = 4'b0001; join_mode = 2'b00;
    expect_push(4, 4'b0001, 16'd3, 4'b0000);
    tick();
    start_valid = 1'b0;
    work_done = 4'b0001;
    chk("launch_busy", 32'(busy_mask), 32'd0);
    tick(); work_done = 4'b0000;
    chk("launch_busy_set", 32'(busy_mask), 32'd1);
    tick();
    tick(); work_done = 4'b0001;
    tick(); work_done = 4'b0000;
    tick(); tick();
    chk("launch_done_err", 32'(err_cnt - e0), 32'd1);
    sb_drain("launch_report_missing");

    // Reset in WAIT abandons the fork.
    start_valid = 1'b1; start_mask = 4'b0011; join_mode = 2'b00;
    tick();
    start_valid = 1'b0;
    tick(); tick(); tick();
    chk("wait_jc_running", 32'(join_cycles), 32'd2);
    rst_n = 1'b0;
    #2;
    chk("midrst_ready", 32'(start_ready), 32'd1);
    chk("midrst_busy", 32'(busy_mask), 32'd0);
    chk("midrst_jc", 32'(join_cycles), 32'd0);
    chk("midrst_done_valid", 32'(done_valid), 32'd0);
    chk("midrst_done_mask", 32'(done_mask), 32'd0);
    chk("midrst_work_go", 32'(work_go), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("postrst_ready", 32'(start_ready), 32'd1);
    e0 = err_cnt;
    work_done = 4'b0001;
    tick(); work_done = '0;
    tick();
    chk("postrst_done_err", 32'(err_cnt - e0), 32'd1);
    chk("postrst_busy", 32'(busy_mask), 32'd0);

    // Latency counter saturation.
    start_valid = 1'b1; start_mask = 4'b0001; join_mode = 2'b00;
    expect_push(65541, 4'b0001, 16'hFFFF, 4'b0000);
    tick();
    start_valid = 1'b0;
    repeat (65539) tick();
    tick(); work_done = 4'b0001;
    tick(); work_done = 4'b0000;
    tick(); tick();
    sb_drain("sat_report_missing");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
